sid_audio_i2s: RTL and testbench
================================

// Module: sid_audio_i2s
// PURPOSE
//  Output stage directly downstream of the SID filter/mixer. Takes the 16-bit mixed SID sample on every clk_en tick and
//  box-car decimates it by 2**DECIM_LOG2. It buffers the result in a small FIFO and serialises it as a 16-bit I2S stream.
//  The same sample drives both left and right slots. The I2S bit clock is derived from clk by an integer divider.
// PARAMETERS
//  DECIM_LOG2   5    decimation = 2**DECIM_LOG2 clk_en ticks per output sample (1..7)
//  BCLK_DIV     8    clk cycles per BCLK half-period (>=2); frame = 64*BCLK_DIV clk
//  FIFO_DEPTH   4    sample FIFO entries, power of 2 (2..16)
// PORTS
//  clk          in   1   system clock
//  n_reset      in   1   asynchronous active-low reset
//  clk_en       in   1   SID tick (~1 MHz), one clk wide
//  audio_in     in   16  signed two's-complement mixed SID sample, valid on clk_en
//  clr_status   in   1   synchronous clear of underrun/overflow
//  i2s_bclk     out  1   I2S bit clock
//  i2s_lrclk    out  1   word select, 0 = left
//  i2s_sdata    out  1   serial data, MSB first, changes on BCLK falling edge
//  underrun     out  1   sticky: frame started with FIFO empty
//  overflow     out  1   sticky: decimated sample dropped, FIFO full
//  peak         out  16  (SID_AUDIO_PEAK_EN only) peak |sample| meter
// BEHAVIOUR
//  Reset: all outputs 0. Accumulator, counters and FIFO cleared. Held-sample register = 0. All flops use async reset.
//  Decimator: on each clk_en, acc += sign-extended audio_in; tick counter increments.
//   - acc width = 16+DECIM_LOG2.
//   - On the 2**DECIM_LOG2-th tick, sample = (acc + audio_in) >>> DECIM_LOG2 (arithmetic, truncating).
//   - The sample is pushed; acc is reloaded to 0 on that same cycle.
//   - Push latency: sample is visible in the FIFO 1 clk after the final clk_en.
//  FIFO: synchronous, FIFO_DEPTH entries, registered count.
//   - Push while full: sample is discarded and overflow is set.
//   - Simultaneous push and pop while full: pop wins its slot, push accepted, no overflow.
//  BCLK gen: div counter 0..BCLK_DIV-1. On wrap, i2s_bclk toggles. A 1->0 toggle is a "fall event".
//  Serialiser FSM: IDLE -> RUN after reset; RUN only thereafter. Bit counter b = 0..31 advances on each fall event, wraps 31->0.
//   - i2s_lrclk = (b >= 16), updated on the fall event.
//   - Entering b=0: pop the FIFO into the held sample. If the FIFO is empty, re-use the held sample and set underrun.
//   - i2s_sdata at b=1..15 = held[15-(b-1)]; at b=17..31 = held[15-(b-17)].
//   - At b=0 and b=16, i2s_sdata = held[0] of the preceding slot (standard I2S 1-bit delay).
//   - First frame after reset: b starts at 31 in IDLE, so the first fall event enters b=0 and pops.
//  clr_status clears both flags the same cycle. A set event in that same cycle wins (flag remains 1).
//  Rate constraint (not checked in RTL): frame rate >= clk_en rate / 2**DECIM_LOG2.
//  Reset mid-frame: bclk/lrclk/sdata drop to 0 immediately; the FIFO content is lost.
// CONFIGURATION
//  SID_AUDIO_PEAK_EN defined:
//   - On each pop, peak = max(peak, |sample|). The magnitude is saturated: -32768 -> 32767.
//   - peak decays by peak>>8 on each b=0 entry without a new maximum.
//  SID_AUDIO_PEAK_EN undefined: port peak, its register and the abs/compare logic are absent.
// STRUCTURE
//  Package sid_audio_pkg:
//   - typedef logic signed [15:0] sample_t
//   - localparam I2S_SLOT_BITS = 16, I2S_FRAME_BITS = 32
//   - typedef enum {SER_IDLE, SER_RUN} ser_state_t
//  Sub-module sid_audio_fifo: parameterised sample_t FIFO with push/pop/full/empty. The decimator, BCLK gen and
//  serialiser stay in this module.
// TESTING
//  1. Constant audio_in=16'h1234, DECIM_LOG2=5: after 32 ticks, FIFO holds 16'h1234; frame shifts 0001001000110100 in both slots.
//  2. audio_in=-1 (16'hFFFF) for 32 ticks -> sample 16'hFFFF. Alternating +100/-101 -> sample = -1 (floor of -0.5).
//  3. Stop clk_en: first empty frame sets underrun and repeats the held word bit-exact. clr_status -> underrun=0.
//  4. BCLK_DIV=2 with a slow frame: fill FIFO_DEPTH+1 samples -> overflow=1, the first 4 samples emitted in order.
//  5. Assert n_reset mid-slot (b=7): all outputs 0 asynchronously. After release, first fall event pops with b=0, lrclk=0.
//  6. SID_AUDIO_PEAK_EN: pop -32768 -> peak=32767. Then silence for 8 frames -> peak decays monotonically (32767->32640 first).

Source files
------------

// File: rtl/sid_audio_pkg.sv
// Shared types and constants for the SID audio I2S output stage.
// SID_AUDIO_PEAK_EN enables the peak meter in sid_audio_i2s.
package sid_audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int I2S_SLOT_BITS  = 16;
    localparam int I2S_FRAME_BITS = 32;

    typedef enum logic {
        SER_IDLE,
        SER_RUN
    } ser_state_t;

    // -32768 has no positive counterpart, so clamp it
    function automatic logic [15:0] sat_abs(input sample_t s);
        logic [15:0] r;
        if (s == 16'sh8000)
            r = 16'h7fff;
        else if (s < 0)
            r = 16'(-s);
        else
            r = 16'(s);
        return r;
    endfunction

endpackage

// File: rtl/sid_audio_fifo.sv
// Small synchronous sample FIFO with registered occupancy count.
// Push while full is ignored unless a pop frees the slot in the same cycle.
module sid_audio_fifo
    import sid_audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    n_reset,
    input  logic    push,
    input  sample_t wdata,
    input  logic    pop,
    output sample_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_pop)
                rp <= rp + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sid_audio_i2s.sv
// SID mixer output stage: box-car decimator, sample FIFO and 16-bit I2S serialiser.
// Define SID_AUDIO_PEAK_EN to add the peak |sample| meter output.
module sid_audio_i2s
    import sid_audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 5,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        clk_en,
    input  logic [15:0] audio_in,
    input  logic        clr_status,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun,
`ifdef SID_AUDIO_PEAK_EN
    output logic        overflow,
    output logic [15:0] peak
`else
    output logic        overflow
`endif
);

    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int DIV_W = $clog2(BCLK_DIV);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_avg;
    logic [DECIM_LOG2-1:0]   tick;
    logic                    dec_push;
    sample_t                 dec_sample;

    assign acc_sum    = acc + {{DECIM_LOG2{audio_in[15]}}, audio_in};
    assign acc_avg    = acc_sum >>> DECIM_LOG2;
    assign dec_sample = acc_avg[15:0];
    assign dec_push   = clk_en && (&tick);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc  <= '0;
            tick <= '0;
        end else if (clk_en) begin
            acc  <= dec_push ? '0 : acc_sum;
            tick <= tick + 1'b1;
        end
    end

    sample_t fifo_rdata;
    logic    fifo_full;
    logic    fifo_empty;
    logic    frame_start;
    logic    pop;

    assign pop = frame_start && !fifo_empty;

    sid_audio_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (dec_push),
        .wdata   (dec_sample),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    logic [DIV_W-1:0] div;
    logic             div_wrap;
    logic             fall;

    assign div_wrap = (div == DIV_W'(BCLK_DIV - 1));
    assign fall     = div_wrap && i2s_bclk;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div      <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_wrap) begin
            div      <= '0;
            i2s_bclk <= !i2s_bclk;
        end else begin
            div <= div + 1'b1;
        end
    end

    ser_state_t state;
    ser_state_t state_nxt;
    logic [4:0] b_cnt;
    logic [4:0] b_nxt;
    logic [3:0] sidx;
    logic       bit_adv;
    sample_t    held;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= SER_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SER_IDLE: if (fall) state_nxt = SER_RUN;
            SER_RUN:  state_nxt = SER_RUN;
            default:  state_nxt = SER_IDLE;
        endcase
    end

    // IDLE parks b at 31 so the first fall event opens a frame
    always_comb begin
        bit_adv     = 1'b0;
        frame_start = 1'b0;
        unique case (state)
            SER_IDLE: begin
                bit_adv     = fall;
                frame_start = fall;
            end
            SER_RUN: begin
                bit_adv     = fall;
                frame_start = fall && (&b_cnt);
            end
            default: ;
        endcase
    end

    // held[-b mod 16]: b=1..15 -> bits 15..1, b=0/16 -> old LSB
    assign b_nxt = b_cnt + 5'd1;
    assign sidx  = 4'd0 - b_nxt[3:0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            b_cnt     <= 5'd31;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            held      <= '0;
        end else if (bit_adv) begin
            b_cnt     <= b_nxt;
            i2s_lrclk <= b_nxt[4];
            i2s_sdata <= held[sidx];
            if (pop)
                held <= fifo_rdata;
        end
    end

    logic set_ur;
    logic set_ov;

    assign set_ur = frame_start && fifo_empty;
    assign set_ov = dec_push && fifo_full && !pop;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            underrun <= set_ur || (underrun && !clr_status);
            overflow <= set_ov || (overflow && !clr_status);
        end
    end

`ifdef SID_AUDIO_PEAK_EN
    logic [15:0] mag;

    assign mag = sat_abs(fifo_rdata);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            peak <= '0;
        else if (frame_start) begin
            if (pop && (mag > peak))
                peak <= mag;
            else
                peak <= peak - (peak >> 8);
        end
    end
`endif

endmodule

// File: tb/tb_sid_audio_i2s.sv
// Directed self-checking bench for sid_audio_i2s (default and fast-BCLK instances).
// Peak meter checks are compiled in with SID_AUDIO_PEAK_EN.
module tb_sid_audio_i2s;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        clk_en;
    logic [15:0] audio_in;
    logic        clr_status;
    logic        bclk, lrclk, sdata, underrun, overflow;
    logic [15:0] peak;

    logic        n_reset2;
    logic        clk_en2;
    logic [15:0] audio2;
    logic        clr2;
    logic        bclk2, lrclk2, sdata2, underrun2, overflow2;
    logic [15:0] peak2;

    int n_tests = 0;
    int n_fail  = 0;

    logic        sel = 1'b0;
    logic        bclk_m, lr_m, sd_m;
    logic [31:0] cap [8];

    assign bclk_m = sel ? bclk2  : bclk;
    assign lr_m   = sel ? lrclk2 : lrclk;
    assign sd_m   = sel ? sdata2 : sdata;

    always #5 clk = ~clk;

    sid_audio_i2s #(.DECIM_LOG2(5), .BCLK_DIV(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .clk_en     (clk_en),
        .audio_in   (audio_in),
        .clr_status (clr_status),
        .i2s_bclk   (bclk),
        .i2s_lrclk  (lrclk),
        .i2s_sdata  (sdata),
        .underrun   (underrun),
`ifdef SID_AUDIO_PEAK_EN
        .overflow   (overflow),
        .peak       (peak)
`else
        .overflow   (overflow)
`endif
    );

    sid_audio_i2s #(.DECIM_LOG2(1), .BCLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clk        (clk),
        .n_reset    (n_reset2),
        .clk_en     (clk_en2),
        .audio_in   (audio2),
        .clr_status (clr2),
        .i2s_bclk   (bclk2),
        .i2s_lrclk  (lrclk2),
        .i2s_sdata  (sdata2),
        .underrun   (underrun2),
`ifdef SID_AUDIO_PEAK_EN
        .overflow   (overflow2),
        .peak       (peak2)
`else
        .overflow   (overflow2)
`endif
    );

`ifndef SID_AUDIO_PEAK_EN
    assign peak  = 16'h0;
    assign peak2 = 16'h0;
`endif

    task automatic wait_lr_fall(output bit ok);
        logic pl;
        pl = lr_m;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (pl && !lr_m) ok = 1'b1;
            pl = lr_m;
        end
    endtask

    // Left word = bits at b=1..16, right word = b=17..31 plus next b=0
    task automatic capture(input int n, output bit ok);
        logic pb;
        int   rises;
        bit   f;
        ok = 1'b0;
        wait_lr_fall(f);
        if (!f) return;
        for (int k = 0; k < 8; k++) cap[k] = 32'h0;
        pb    = bclk_m;
        rises = 0;
        for (int c = 0; c < 1200 * (n + 1) && !ok; c++) begin
            @(negedge clk);
            if (!pb && bclk_m) begin
                if (rises > 0)
                    cap[(rises - 1) / 32] = {cap[(rises - 1) / 32][30:0], sd_m};
                rises++;
                if (rises == 1 + 32 * n) ok = 1'b1;
            end
            pb = bclk_m;
        end
    endtask

    task automatic feed(input logic [15:0] v0, input logic [15:0] v1, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_en   = 1'b1;
            audio_in = (i % 2 == 0) ? v0 : v1;
            @(negedge clk);
            clk_en = 1'b0;
        end
    endtask

    task automatic feed_and_check(input string nm, input logic [15:0] v0,
                                  input logic [15:0] v1, input logic [15:0] exp);
        bit ok;
        feed(v0, v1, 32);
        capture(1, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: frame capture timed out", nm);
        end else if (cap[0] !== {exp, exp}) begin
            n_fail++;
            $display("FAIL %s: frame got %h want %h", nm, cap[0], {exp, exp});
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; clk_en = 1'b0; audio_in = '0; clr_status = 1'b0;
        n_reset2 = 1'b0; clk_en2 = 1'b0; audio2 = '0; clr2 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bclk, lrclk, sdata, underrun, overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 00000",
                     {bclk, lrclk, sdata, underrun, overflow});
        end
        n_tests++;
        if ({bclk2, lrclk2, sdata2, underrun2, overflow2} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs2: got %b want 00000",
                     {bclk2, lrclk2, sdata2, underrun2, overflow2});
        end
        n_tests++;
        if (peak !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_peak: got %h want 0000", peak);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_decimate();
        feed_and_check("const_1234", 16'h1234, 16'h1234, 16'h1234);
        feed_and_check("alt_100_m101", 16'd100, 16'hff9b, 16'hffff);
        feed_and_check("const_8000", 16'h8000, 16'h8000, 16'h8000);
        feed_and_check("const_ffff", 16'hffff, 16'hffff, 16'hffff);
        feed_and_check("const_5a5a", 16'h5a5a, 16'h5a5a, 16'h5a5a);
    endtask

    task automatic test_underrun();
        bit ok;
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: got %b want 1", underrun);
        end
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
        n_tests++;
        if ({underrun, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_status: got %b want 00", {underrun, overflow});
        end
        capture(2, ok);
        n_tests++;
        if (!ok || cap[0] !== 32'h5a5a5a5a || cap[1] !== 32'h5a5a5a5a) begin
            n_fail++;
            $display("FAIL underrun_repeat: got %h %h want 5a5a5a5a", cap[0], cap[1]);
        end
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_empty: got %b want 1", underrun);
        end
    endtask

    task automatic test_reset_mid_slot();
        bit ok;
        wait_lr_fall(ok);
        repeat (121) @(negedge clk);
        n_tests++;
        if (!ok || {bclk, lrclk, sdata} !== 3'b101) begin
            n_fail++;
            $display("FAIL pre_reset_b7: got %b want 101", {bclk, lrclk, sdata});
        end
        #1 n_reset = 1'b0;
        #1;
        n_tests++;
        if ({bclk, lrclk, sdata, underrun, overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 00000",
                     {bclk, lrclk, sdata, underrun, overflow});
        end
        @(negedge clk) n_reset = 1'b1;
        repeat (15) @(negedge clk);
        n_tests++;
        if ({bclk, underrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL before_first_fall: got %b want 10", {bclk, underrun});
        end
        @(negedge clk);
        n_tests++;
        if ({bclk, lrclk, underrun} !== 3'b001) begin
            n_fail++;
            $display("FAIL first_fall_pop: got %b want 001", {bclk, lrclk, underrun});
        end
        capture(1, ok);
        n_tests++;
        if (!ok || cap[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL held_after_reset: got %h want 00000000", cap[0]);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] vals [5];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        vals[3] = 16'h4444; vals[4] = 16'h5555;
        @(negedge clk) n_reset2 = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            clk_en2 = 1'b1;
            audio2  = vals[i / 2];
            @(negedge clk);
        end
        clk_en2 = 1'b0;
        n_tests++;
        if ({overflow2, underrun2} !== 2'b11) begin
            n_fail++;
            $display("FAIL overflow_set: got %b want 11", {overflow2, underrun2});
        end
        sel = 1'b1;
        capture(5, ok);
        sel = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL overflow_capture: timed out");
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (cap[k] !== {vals[k < 4 ? k : 3], vals[k < 4 ? k : 3]}) begin
                n_fail++;
                $display("FAIL overflow_order_%0d: got %h want %h", k, cap[k],
                         {vals[k < 4 ? k : 3], vals[k < 4 ? k : 3]});
            end
        end
        @(negedge clk); clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0;
        n_tests++;
        if (overflow2 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clr: got %b want 0", overflow2);
        end
    endtask

`ifdef SID_AUDIO_PEAK_EN
    task automatic test_peak();
        bit ok;
        logic [15:0] p;
        @(negedge clk) n_reset = 1'b0;
        @(negedge clk) n_reset = 1'b1;
        feed(16'h8000, 16'h8000, 32);
        wait_lr_fall(ok);
        p = 16'd32767;
        n_tests++;
        if (!ok || peak !== p) begin
            n_fail++;
            $display("FAIL peak_sat: got %h want %h", peak, p);
        end
        for (int f = 0; f < 8; f++) begin
            wait_lr_fall(ok);
            p = p - (p >> 8);
            n_tests++;
            if (!ok || peak !== p) begin
                n_fail++;
                $display("FAIL peak_decay_%0d: got %0d want %0d", f, peak, p);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decimate();
        test_underrun();
        test_reset_mid_slot();
        test_overflow();
`ifdef SID_AUDIO_PEAK_EN
        test_peak();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
